// File: rtl/seven_segment_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_pkg
// Description : Shared glyph table, segment type and pattern decoder for the
//               seven-segment capture block. Patterns are active-low {g..a}.
// Revision    : 1.0 - initial release
// ============================================================================
package seven_segment_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0011000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef struct packed {
    logic [3:0] hex;
    logic       blank;
    logic       err;
  } seg_dec_t;

  // Unknown patterns and blank both report hex=0; the flags tell them apart.
  function automatic seg_dec_t seg_decode(input seg_t seg);
    seg_dec_t r;
    r.hex   = 4'h0;
    r.blank = 1'b0;
    r.err   = 1'b0;
    case (seg)
      SEG_0:     r.hex = 4'h0;
      SEG_1:     r.hex = 4'h1;
      SEG_2:     r.hex = 4'h2;
      SEG_3:     r.hex = 4'h3;
      SEG_4:     r.hex = 4'h4;
      SEG_5:     r.hex = 4'h5;
      SEG_6:     r.hex = 4'h6;
      SEG_7:     r.hex = 4'h7;
      SEG_8:     r.hex = 4'h8;
      SEG_9:     r.hex = 4'h9;
      SEG_A:     r.hex = 4'hA;
      SEG_B:     r.hex = 4'hB;
      SEG_C:     r.hex = 4'hC;
      SEG_D:     r.hex = 4'hD;
      SEG_E:     r.hex = 4'hE;
      SEG_F:     r.hex = 4'hF;
      SEG_BLANK: r.blank = 1'b1;
      default:   r.err = 1'b1;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_segment_decode.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_decode
// Description : Combinational active-low segment pattern to {hex, blank, err}.
// Ports       : i_seg   - segment pattern {g..a}, active-low
//               o_hex   - decoded nibble (0 for blank / unknown)
//               o_blank - pattern is all segments off
//               o_err   - pattern is neither a hex glyph nor blank
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_decode
  import seven_segment_pkg::*;
(
  input  seg_t       i_seg,
  output logic [3:0] o_hex,
  output logic       o_blank,
  output logic       o_err
);

  seg_dec_t w_dec;

  always_comb begin
    w_dec   = seg_decode(i_seg);
    o_hex   = w_dec.hex;
    o_blank = w_dec.blank;
    o_err   = w_dec.err;
  end

endmodule
`default_nettype wire

// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_capture
// Description : Receiver for a multiplexed active-low seven-segment bus.
//               Synchronizes segment/select lines, waits for a stable run,
//               decodes the pattern and commits it to a per-digit register
//               file and a one-entry valid/ready event buffer.
// Ports       : i_clk, i_rst_n        - clock, async active-low reset
//               i_segment, i_digit_sel_n - asynchronous display bus
//               o_hex/o_blank/o_err   - per-digit last committed result
//               o_valid/i_ready/o_evt_* - event stream
//               o_overflow            - sticky event-dropped flag
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_capture
  import seven_segment_pkg::*;
#(
  parameter int N_DIGITS      = 4,
  parameter int STABLE_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [6:0]            i_segment,
  input  logic [N_DIGITS-1:0]   i_digit_sel_n,
  output logic [4*N_DIGITS-1:0] o_hex,
  output logic [N_DIGITS-1:0]   o_blank,
  output logic [N_DIGITS-1:0]   o_err,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2:0]            o_evt_idx,
  output logic [3:0]            o_evt_hex,
  output logic                  o_evt_blank,
  output logic                  o_evt_err,
  output logic                  o_overflow
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ARM = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

  // Synchronizer stages, the sample stage and the previous sample.
  seg_t                  seg_s1_q, seg_s1_d, seg_smp_q, seg_smp_d, seg_prev_q, seg_prev_d;
  logic [N_DIGITS-1:0]   sel_s1_q, sel_s1_d, sel_smp_q, sel_smp_d, sel_prev_q, sel_prev_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] hex_q, hex_d;
  logic [N_DIGITS-1:0]   blank_q, blank_d, err_q, err_d;
  logic                  valid_q, valid_d, ovf_q, ovf_d;
  logic [2:0]            evt_idx_q, evt_idx_d;
  logic [3:0]            evt_hex_q, evt_hex_d;
  logic                  evt_blank_q, evt_blank_d, evt_err_q, evt_err_d;

  logic [3:0] w_zero_cnt;
  logic [2:0] w_sel_idx;
  logic       w_sel_ok, w_stable, w_commit;
  logic [3:0] w_dec_hex;
  logic       w_dec_blank, w_dec_err;

  seven_segment_decode u_decode (
    .i_seg   (seg_smp_q),
    .o_hex   (w_dec_hex),
    .o_blank (w_dec_blank),
    .o_err   (w_dec_err)
  );

  // Select is usable only with exactly one active (low) line; this rejects
  // inter-digit blanking (none active) and ghosting (several active).
  always_comb begin
    w_zero_cnt = 4'd0;
    w_sel_idx  = 3'd0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (!sel_smp_q[k]) begin
        w_zero_cnt = w_zero_cnt + 4'd1;
        w_sel_idx  = 3'(k);
      end
    end
    w_sel_ok = (w_zero_cnt == 4'd1);
  end

  always_comb begin
    seg_s1_d   = i_segment;
    sel_s1_d   = i_digit_sel_n;
    seg_smp_d  = seg_s1_q;
    sel_smp_d  = sel_s1_q;
    seg_prev_d = seg_smp_q;
    sel_prev_d = sel_smp_q;

    w_stable = (seg_smp_q == seg_prev_q) && (sel_smp_q == sel_prev_q) && w_sel_ok;
    // The counter saturates one above the arm point, so a held pattern
    // passes through the arm->max transition exactly once.
    w_commit = w_stable && (cnt_q == C_CNT_ARM);
    cnt_d    = '0;
    if (w_stable) begin
      cnt_d = (cnt_q == C_CNT_MAX) ? cnt_q : cnt_q + C_CNT_ONE;
    end

    hex_d   = hex_q;
    blank_d = blank_q;
    err_d   = err_q;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (w_commit && !sel_smp_q[k]) begin
        hex_d[4*k +: 4] = w_dec_hex;
        blank_d[k]      = w_dec_blank;
        err_d[k]        = w_dec_err;
      end
    end

    valid_d     = valid_q && !i_ready;
    evt_idx_d   = evt_idx_q;
    evt_hex_d   = evt_hex_q;
    evt_blank_d = evt_blank_q;
    evt_err_d   = evt_err_q;
    ovf_d       = ovf_q;
    if (w_commit) begin
      // A slot being popped this cycle is free for the new event.
      if (!valid_q || i_ready) begin
        valid_d     = 1'b1;
        evt_idx_d   = w_sel_idx;
        evt_hex_d   = w_dec_hex;
        evt_blank_d = w_dec_blank;
        evt_err_d   = w_dec_err;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      seg_s1_q    <= '1;
      sel_s1_q    <= '1;
      seg_smp_q   <= '1;
      sel_smp_q   <= '1;
      seg_prev_q  <= '1;
      sel_prev_q  <= '1;
      cnt_q       <= '0;
      hex_q       <= '0;
      blank_q     <= '1;
      err_q       <= '0;
      valid_q     <= 1'b0;
      evt_idx_q   <= '0;
      evt_hex_q   <= '0;
      evt_blank_q <= 1'b0;
      evt_err_q   <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      seg_s1_q    <= seg_s1_d;
      sel_s1_q    <= sel_s1_d;
      seg_smp_q   <= seg_smp_d;
      sel_smp_q   <= sel_smp_d;
      seg_prev_q  <= seg_prev_d;
      sel_prev_q  <= sel_prev_d;
      cnt_q       <= cnt_d;
      hex_q       <= hex_d;
      blank_q     <= blank_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      evt_idx_q   <= evt_idx_d;
      evt_hex_q   <= evt_hex_d;
      evt_blank_q <= evt_blank_d;
      evt_err_q   <= evt_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign o_hex       = hex_q;
  assign o_blank     = blank_q;
  assign o_err       = err_q;
  assign o_valid     = valid_q;
  assign o_evt_idx   = evt_idx_q;
  assign o_evt_hex   = evt_hex_q;
  assign o_evt_blank = evt_blank_q;
  assign o_evt_err   = evt_err_q;
  assign o_overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_seven_segment_capture
// Description : Self-checking bench for seven_segment_capture (4 digits,
//               16-cycle stability). Table of digit/glyph vectors plus
//               hand-written latency, glitch, ghosting, overflow and reset
//               sequences; events are matched against a scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_capture;
  import seven_segment_pkg::*;

  localparam int N = 4;
  localparam int S = 16;

  typedef struct packed {
    logic [2:0] idx;
    logic [3:0] hex;
    logic       blank;
    logic       err;
  } evt_t;

  typedef struct {
    logic [3:0] sel_n;
    seg_t       seg;
    logic [2:0] idx;
    logic [3:0] hex;
    logic       blank;
    logic       err;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  seg_t          seg;
  logic [N-1:0]  sel_n;
  logic [4*N-1:0] o_hex;
  logic [N-1:0]  o_blank, o_err;
  logic          o_valid, ready;
  logic [2:0]    o_evt_idx;
  logic [3:0]    o_evt_hex;
  logic          o_evt_blank, o_evt_err, o_overflow;

  int n_checks = 0;
  int n_errors = 0;
  int n_events = 0;
  evt_t sb[$];

  logic [4*N-1:0] exp_hex;
  logic [N-1:0]   exp_blank, exp_err;
  vec_t           vecs[20];
  seg_t           glyph[16];

  seven_segment_capture #(.N_DIGITS(N), .STABLE_CYCLES(S)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_segment    (seg),
    .i_digit_sel_n(sel_n),
    .o_hex        (o_hex),
    .o_blank      (o_blank),
    .o_err        (o_err),
    .o_valid      (o_valid),
    .i_ready      (ready),
    .o_evt_idx    (o_evt_idx),
    .o_evt_hex    (o_evt_hex),
    .o_evt_blank  (o_evt_blank),
    .o_evt_err    (o_evt_err),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfers happen on the next rising edge; look at them mid-cycle.
  always @(negedge clk) begin
    if (rst_n && o_valid && ready) begin
      evt_t e;
      n_events++;
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got idx=%0d hex=%0h blank=%0b err=%0b expected none",
                 o_evt_idx, o_evt_hex, o_evt_blank, o_evt_err);
      end else begin
        e = sb.pop_front();
        check("evt_payload", 32'({o_evt_idx, o_evt_hex, o_evt_blank, o_evt_err}), 32'(e));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] s, input seg_t g);
    sel_n = s;
    seg   = g;
  endtask

  task automatic model_commit(input int d, input logic [3:0] h, input logic b,
                              input logic e, input bit push);
    evt_t ev;
    exp_hex[4*d +: 4] = h;
    exp_blank[d]      = b;
    exp_err[d]        = e;
    ev.idx   = 3'(d);
    ev.hex   = h;
    ev.blank = b;
    ev.err   = e;
    if (push) sb.push_back(ev);
  endtask

  task automatic check_regfile(input string name);
    check({name, "_hex"}, 32'(o_hex), 32'(exp_hex));
    check({name, "_blank"}, 32'(o_blank), 32'(exp_blank));
    check({name, "_err"}, 32'(o_err), 32'(exp_err));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_hex"}, 32'(o_hex), 32'h0);
    check({name, "_blank"}, 32'(o_blank), 32'hF);
    check({name, "_err"}, 32'(o_err), 32'h0);
    check({name, "_valid"}, 32'(o_valid), 32'h0);
    check({name, "_ovf"}, 32'(o_overflow), 32'h0);
    check({name, "_evt"}, 32'({o_evt_idx, o_evt_hex, o_evt_blank, o_evt_err}), 32'h0);
  endtask

  initial begin
    int ev0;
    glyph = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
              SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
    for (int i = 0; i < 16; i++) begin
      vecs[i].sel_n = ~(4'(1) << (i % 4));
      vecs[i].seg   = glyph[i];
      vecs[i].idx   = 3'(i % 4);
      vecs[i].hex   = 4'(i);
      vecs[i].blank = 1'b0;
      vecs[i].err   = 1'b0;
    end
    vecs[16] = '{sel_n: 4'b1110, seg: SEG_F,      idx: 3'd0, hex: 4'hF, blank: 1'b0, err: 1'b0};
    vecs[17] = '{sel_n: 4'b1101, seg: SEG_0,      idx: 3'd1, hex: 4'h0, blank: 1'b0, err: 1'b0};
    vecs[18] = '{sel_n: 4'b1011, seg: SEG_BLANK,  idx: 3'd2, hex: 4'h0, blank: 1'b1, err: 1'b0};
    vecs[19] = '{sel_n: 4'b0111, seg: 7'b1100110, idx: 3'd3, hex: 4'h0, blank: 1'b0, err: 1'b1};

    exp_hex = '0; exp_blank = '1; exp_err = '0;
    ready = 1'b1;
    rst_n = 1'b0;
    drive('1, SEG_BLANK);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);
    check_reset_outputs("reset");

    // Latency: o_valid rises 18 edges after the drive.
    drive(4'b1101, SEG_2);
    model_commit(1, 4'h2, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      cyc(1);
      if (k == 17) check("valid_early", 32'(o_valid), 32'h0);
      if (k == 18) begin
        check("valid_on_time", 32'(o_valid), 32'h1);
        check("first_evt", 32'({o_evt_idx, o_evt_hex}), 32'({3'd1, 4'h2}));
        check("first_slot", 32'(o_hex[7:4]), 32'h2);
      end
    end
    cyc(200 - 18);
    check("held_single_event", 32'(n_events), 32'd1);
    drive('1, SEG_BLANK);
    cyc(10);

    // Table: every glyph, then the digit scan with blank and bad pattern.
    ev0 = n_events;
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].sel_n, vecs[i].seg);
      model_commit(int'(vecs[i].idx), vecs[i].hex, vecs[i].blank, vecs[i].err, 1'b1);
      cyc(40);
      drive('1, SEG_BLANK);
      cyc(10);
      check($sformatf("vec%0d_slot", i),
            32'({o_hex[4*vecs[i].idx +: 4], o_blank[vecs[i].idx], o_err[vecs[i].idx]}),
            32'({vecs[i].hex, vecs[i].blank, vecs[i].err}));
    end
    check("table_events", 32'(n_events - ev0), 32'd20);
    check("scan_hex", 32'(o_hex), 32'h000F);
    check("scan_blank", 32'(o_blank), 32'b0100);
    check("scan_err", 32'(o_err), 32'b1000);

    // One-cycle glitch every 10 cycles never lets the run reach 16.
    ev0 = n_events;
    for (int i = 0; i < 100; i++) begin
      drive(4'b1110, (i % 10 == 0) ? SEG_9 : SEG_8);
      cyc(1);
    end
    drive('1, SEG_BLANK);
    cyc(10);
    check("glitch_no_event", 32'(n_events - ev0), 32'd0);
    check_regfile("glitch");

    // Two selects active: never committed.
    drive(4'b1001, SEG_8);
    cyc(100);
    drive('1, SEG_BLANK);
    cyc(10);
    check("ghost_no_event", 32'(n_events - ev0), 32'd0);
    check_regfile("ghost");

    // Overflow: first event held, second dropped but register file updated.
    ready = 1'b0;
    drive(4'b1110, SEG_5);
    model_commit(0, 4'h5, 1'b0, 1'b0, 1'b1);
    cyc(40);
    check("ovf_first_valid", 32'(o_valid), 32'h1);
    check("ovf_first_evt", 32'({o_evt_idx, o_evt_hex}), 32'({3'd0, 4'h5}));
    check("ovf_not_yet", 32'(o_overflow), 32'h0);
    drive('1, SEG_BLANK);
    cyc(10);
    drive(4'b1101, SEG_7);
    model_commit(1, 4'h7, 1'b0, 1'b0, 1'b0);
    cyc(40);
    check("ovf_held_evt", 32'({o_valid, o_evt_idx, o_evt_hex, o_evt_blank, o_evt_err}),
          32'({1'b1, 3'd0, 4'h5, 1'b0, 1'b0}));
    check("ovf_set", 32'(o_overflow), 32'h1);
    check_regfile("ovf");
    drive('1, SEG_BLANK);
    cyc(10);
    ev0 = n_events;
    ready = 1'b1;
    cyc(4);
    check("ovf_one_transfer", 32'(n_events - ev0), 32'd1);
    check("ovf_drained", 32'(o_valid), 32'h0);
    check("ovf_sticky", 32'(o_overflow), 32'h1);

    // Reset in the middle of a stable run.
    drive(4'b1011, SEG_3);
    cyc(8);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_hex = '0; exp_blank = '1; exp_err = '0;
    sb.delete();
    cyc(2);
    rst_n = 1'b1;
    model_commit(2, 4'h3, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      cyc(1);
      if (k == 17) check("post_reset_early", 32'(o_valid), 32'h0);
      if (k == 18) check("post_reset_valid", 32'(o_valid), 32'h1);
    end
    cyc(5);
    check_regfile("post_reset");
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_segment_capture.md
# seven_segment_capture

Sequential receiver for a multiplexed, active-low seven-segment display bus. It samples the segment lines and digit-select lines, and waits until each digit's pattern is stable. It then decodes the pattern back to a hex nibble and publishes the result as a per-digit register file plus a valid/ready event stream. It sits at the far end of the display path and serves as the loopback checker for display drivers, and as a front-end for capturing external seven-segment equipment.

## Interface
Parameters:
- N_DIGITS, 4: number of multiplexed digits (1..8)
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before commit (2..65535)

Ports:
- i_clk  input  1  system clock, single clock domain
- i_rst_n  input  1  reset, asynchronous assert, active-low
- i_segment  input  7  segment lines {g,f,e,d,c,b,a}; active-low (0 = lit); asynchronous to i_clk
- i_digit_sel_n  input  N_DIGITS  digit anode select; active-low one-hot; asynchronous
- o_hex  output  4*N_DIGITS  last committed nibble per digit; digit k at [4k+3:4k]
- o_blank  output  N_DIGITS  digit k last committed as all-segments-off
- o_err  output  N_DIGITS  digit k last committed pattern not one of the 16 hex glyphs or blank
- o_valid  output  1  event stream valid
- i_ready  input  1  event stream ready
- o_evt_idx  output  3  digit index of event
- o_evt_hex  output  4  nibble of event
- o_evt_blank, o_evt_err  output  1 each  flags of event
- o_overflow  output  1  sticky: an event was dropped; cleared only by reset

## Operation
- Glyph set (active-low {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
  - blank=1111111
- Any other pattern decodes to hex=0, err=1.
- Blank decodes to hex=0, blank=1, err=0.
- Both i_segment and i_digit_sel_n pass through a 2-flop synchronizer. Decisions use only the second flop, called "sample".
- Stability counter cnt, width $clog2(STABLE_CYCLES+1):
  - sample equals previous sample and select valid: cnt = min(cnt+1, STABLE_CYCLES-1).
  - Otherwise: cnt = 0.
- Select is valid only when exactly one bit of sample select is 0. If zero or multiple bits are active, the sample is never committed. This covers inter-digit blanking and ghosting.
- Commit happens on the single cycle where cnt goes from STABLE_CYCLES-2 to STABLE_CYCLES-1. At most one commit per stable run; a held pattern never re-commits.
- Commit writes the hex/blank/err slot of the selected digit and generates an event.
- Event buffer is one entry:
  - Slot empty, or being consumed this cycle (o_valid && i_ready): load the event and assert o_valid next cycle.
  - Slot full and not consumed: drop the new event, keep the old one, set o_overflow.
  - The register-file update happens regardless of event-buffer state.
- o_evt_* are stable while o_valid && !i_ready.
- Reset values: o_hex=0, o_blank=all 1, o_err=0, o_valid=0, o_evt_*=0, o_overflow=0, cnt=0. Synchronizers reset to all 1 (bus idle).
- Reset mid-run discards the partial stability count and any pending event.

## Timing
- New input value present at sampling edge T: sample reflects it at T+2.
- Commit asserts STABLE_CYCLES-1 cycles after that, at T+STABLE_CYCLES+1.
- o_hex/o_blank/o_err and o_valid update at T+STABLE_CYCLES+2.
- A one-cycle input glitch resets cnt. The earliest commit is then STABLE_CYCLES+1 cycles after the glitch clears.
- Handshake: the transfer occurs on any edge with o_valid && i_ready.
- Back-to-back events sustain one per cycle when i_ready=1.
- Commit and pop in the same cycle: o_valid stays 1 with the new payload and no overflow.

## Structure
- seven_segment_pkg holds:
  - the 16 glyph constants and SEG_BLANK
  - typedef seg_t (logic [6:0])
  - function seg_decode(seg_t) returning struct {hex, blank, err}
- One sub-module, seven_segment_decode: combinational pattern to {hex, blank, err}, wrapping seg_decode.
- The synchronizer is inline; no separate module.

## Test plan
- Reset, then N_DIGITS=4, STABLE_CYCLES=16:
  - Outputs: o_hex=16'h0000, o_blank=4'b1111, o_valid=0.
  - Drive sel_n=1101, seg=0100100 steady. o_valid rises exactly 18 cycles after the first sampling edge, with idx=1, hex=2; o_hex[7:4]=2.
- Hold that pattern for 200 cycles with i_ready=1: exactly one event.
- Scan digits 0..3 with glyphs F, 0, blank, 1100110, 40 cycles each with sel_n=1111 gaps:
  - Events in order: (0,F), (1,0), (2,blank=1), (3,err=1).
  - o_hex=16'h00_0F with digits 2 and 3 reading 0, o_blank=4'b0100, o_err=4'b1000.
- Toggle seg for one cycle every 10 cycles with STABLE_CYCLES=16: no event is ever produced.
- sel_n=1001 (two digits active) steady for 100 cycles: no event, register file unchanged.
- i_ready=0, then commit two digits: first event is held stable and o_overflow=1 after the second commit. Raise i_ready: one transfer of the first event only. Assert i_rst_n=0 mid-stability: all outputs return to reset values, and the next commit occurs only after a full fresh STABLE_CYCLES run.
